// File: rtl/score_hex_display.sv
// score_hex_display: snapshots four 5-bit values, converts each to two BCD
// digits with a shared shift-add-3 engine, and drives eight active-low
// 7-segment displays. All displays are updated together in a single cycle.
module score_hex_display #(
    parameter int REFRESH_PERIOD     = 0,
    parameter bit BLANK_LEADING_ZERO = 1'b0
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] in1,
    input  logic [4:0] in2,
    input  logic [4:0] in3,
    input  logic [4:0] in4,
    output logic [6:0] HEX7,
    output logic [6:0] HEX6,
    output logic [6:0] HEX5,
    output logic [6:0] HEX4,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        LOAD,
        SHIFT,
        STORE,
        COMMIT
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Refresh counter sized to hold 0..REFRESH_PERIOD-1; a single bit when unused.
    localparam int CNT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [CNT_W-1:0] REFRESH_LAST =
        CNT_W'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] refresh_cnt;
    logic             auto_fire;
    logic             trigger;
    logic [4:0]       snap [4];
    logic [5:0]       digits [4];
    logic [1:0]       channel;
    logic [4:0]       shift_reg;
    logic [1:0]       tens;
    logic [3:0]       ones;
    logic [3:0]       ones_adj;
    logic [2:0]       bit_cnt;

    // Decode one BCD digit to active-low segments {g,f,e,d,c,b,a}; non-digits go blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Tens digit decode, optionally suppressing a leading zero.
    function automatic logic [6:0] tens_seg(input logic [1:0] t);
        if (BLANK_LEADING_ZERO && (t == 2'd0)) begin
            return SEG_BLANK;
        end
        return seg7({2'b00, t});
    endfunction

    assign auto_fire = (REFRESH_PERIOD != 0) && (refresh_cnt == REFRESH_LAST);
    assign trigger   = start | auto_fire;
    assign ones_adj  = (ones >= 4'd5) ? (ones + 4'd3) : ones;

    // Free-running refresh counter; keeps counting regardless of FSM state.
    always_ff @(posedge Clock) begin
        if (reset) begin
            refresh_cnt <= '0;
        end else if (REFRESH_PERIOD == 0) begin
            refresh_cnt <= '0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: capture, then four LOAD/SHIFT/STORE passes, then commit.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (trigger) next_state = CAPTURE;
            CAPTURE: next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (bit_cnt == 3'd4) next_state = STORE;
            STORE:   next_state = (channel == 2'd3) ? COMMIT : LOAD;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: snapshot, double-dabble conversion, digit buffer and display registers.
    always_ff @(posedge Clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                snap[i]   <= '0;
                digits[i] <= '0;
            end
            channel   <= '0;
            shift_reg <= '0;
            tens      <= '0;
            ones      <= '0;
            bit_cnt   <= '0;
            HEX7      <= SEG_BLANK;
            HEX6      <= SEG_BLANK;
            HEX5      <= SEG_BLANK;
            HEX4      <= SEG_BLANK;
            HEX3      <= SEG_BLANK;
            HEX2      <= SEG_BLANK;
            HEX1      <= SEG_BLANK;
            HEX0      <= SEG_BLANK;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == COMMIT);
            busy <= (state != IDLE) && (state != COMMIT);
            case (state)
                CAPTURE: begin
                    snap[0] <= in1;
                    snap[1] <= in2;
                    snap[2] <= in3;
                    snap[3] <= in4;
                    channel <= '0;
                end
                LOAD: begin
                    shift_reg <= snap[channel];
                    tens      <= '0;
                    ones      <= '0;
                    bit_cnt   <= '0;
                end
                SHIFT: begin
                    tens      <= {tens[0], ones_adj[3]};
                    ones      <= {ones_adj[2:0], shift_reg[4]};
                    shift_reg <= {shift_reg[3:0], 1'b0};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                STORE: begin
                    digits[channel] <= {tens, ones};
                    if (channel != 2'd3) begin
                        channel <= channel + 2'd1;
                    end
                end
                COMMIT: begin
                    HEX7 <= tens_seg(digits[0][5:4]);
                    HEX6 <= seg7(digits[0][3:0]);
                    HEX5 <= tens_seg(digits[1][5:4]);
                    HEX4 <= seg7(digits[1][3:0]);
                    HEX3 <= tens_seg(digits[2][5:4]);
                    HEX2 <= seg7(digits[2][3:0]);
                    HEX1 <= tens_seg(digits[3][5:4]);
                    HEX0 <= seg7(digits[3][3:0]);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_hex_display.sv
// tb_score_hex_display: scoreboard bench for score_hex_display with three
// instances: default parameters, auto refresh every 64 cycles, and leading-zero blanking.
module tb_score_hex_display;

    localparam logic [6:0]  BLANK     = 7'b1111111;
    localparam logic [55:0] ALL_BLANK = {8{BLANK}};

    logic       Clock = 1'b0;
    logic       reset;
    logic       start_a, start_b, start_r;
    logic [4:0] a1, a2, a3, a4, b1, b2, b3, b4, r1, r2, r3, r4;
    logic [6:0] hex_a [8];
    logic [6:0] hex_b [8];
    logic [6:0] hex_r [8];
    logic       busy_a, busy_b, busy_r, done_a, done_b, done_r;
    logic [55:0] vec_a, vec_b, vec_r;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [55:0] q_a [$];
    logic [55:0] q_b [$];
    logic [55:0] q_r [$];
    logic [55:0] last_a;

    // 100 MHz-style free-running clock.
    always #5 Clock = ~Clock;

    assign vec_a = {hex_a[7], hex_a[6], hex_a[5], hex_a[4], hex_a[3], hex_a[2], hex_a[1], hex_a[0]};
    assign vec_b = {hex_b[7], hex_b[6], hex_b[5], hex_b[4], hex_b[3], hex_b[2], hex_b[1], hex_b[0]};
    assign vec_r = {hex_r[7], hex_r[6], hex_r[5], hex_r[4], hex_r[3], hex_r[2], hex_r[1], hex_r[0]};

    score_hex_display dut_a (
        .Clock(Clock), .reset(reset), .start(start_a),
        .in1(a1), .in2(a2), .in3(a3), .in4(a4),
        .HEX7(hex_a[7]), .HEX6(hex_a[6]), .HEX5(hex_a[5]), .HEX4(hex_a[4]),
        .HEX3(hex_a[3]), .HEX2(hex_a[2]), .HEX1(hex_a[1]), .HEX0(hex_a[0]),
        .busy(busy_a), .done(done_a)
    );

    score_hex_display #(.REFRESH_PERIOD(0), .BLANK_LEADING_ZERO(1'b1)) dut_b (
        .Clock(Clock), .reset(reset), .start(start_b),
        .in1(b1), .in2(b2), .in3(b3), .in4(b4),
        .HEX7(hex_b[7]), .HEX6(hex_b[6]), .HEX5(hex_b[5]), .HEX4(hex_b[4]),
        .HEX3(hex_b[3]), .HEX2(hex_b[2]), .HEX1(hex_b[1]), .HEX0(hex_b[0]),
        .busy(busy_b), .done(done_b)
    );

    score_hex_display #(.REFRESH_PERIOD(64), .BLANK_LEADING_ZERO(1'b0)) dut_r (
        .Clock(Clock), .reset(reset), .start(start_r),
        .in1(r1), .in2(r2), .in3(r3), .in4(r4),
        .HEX7(hex_r[7]), .HEX6(hex_r[6]), .HEX5(hex_r[5]), .HEX4(hex_r[4]),
        .HEX3(hex_r[3]), .HEX2(hex_r[2]), .HEX1(hex_r[1]), .HEX0(hex_r[0]),
        .busy(busy_r), .done(done_r)
    );

    // Reference segment table.
    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    // Expected {HEX7..HEX0} for four values, using plain decimal arithmetic.
    function automatic logic [55:0] model(input int v1, input int v2, input int v3, input int v4, input bit blz);
        int v [4];
        int t, o;
        logic [55:0] r;
        v = '{v1, v2, v3, v4};
        r = '0;
        for (int i = 0; i < 4; i++) begin
            t = v[i] / 10;
            o = v[i] % 10;
            r = {r[41:0], ((blz && t == 0) ? BLANK : seg(t)), seg(o)};
        end
        return r;
    endfunction

    function automatic logic sel_done(input int which);
        if (which == 0) return done_a;
        if (which == 1) return done_b;
        return done_r;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // Waits up to budget edges for a done pulse; cycles = -1 when it never came.
    task automatic wait_done(input int which, input int budget, output int cycles);
        cycles = -1;
        for (int k = 1; k <= budget && cycles < 0; k++) begin
            tick();
            if (sel_done(which) === 1'b1) cycles = k;
        end
    endtask

    task automatic test_reset();
        int seen;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n_compared++; if (vec_a !== ALL_BLANK) begin n_mismatched++; $display("[TB] FAIL reset_hex_a: got %h want %h", vec_a, ALL_BLANK); end
        n_compared++; if (vec_b !== ALL_BLANK) begin n_mismatched++; $display("[TB] FAIL reset_hex_b: got %h want %h", vec_b, ALL_BLANK); end
        n_compared++; if (vec_r !== ALL_BLANK) begin n_mismatched++; $display("[TB] FAIL reset_hex_r: got %h want %h", vec_r, ALL_BLANK); end
        n_compared++; if (busy_a !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy_a); end
        n_compared++; if (done_a !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b want 0", done_a); end
        seen = 0;
        repeat (40) begin
            tick();
            if (done_a !== 1'b0 || busy_a !== 1'b0) seen++;
        end
        n_compared++; if (seen !== 0) begin n_mismatched++; $display("[TB] FAIL idle_activity: got %0d cycles want 0", seen); end
        n_compared++; if (vec_a !== ALL_BLANK) begin n_mismatched++; $display("[TB] FAIL idle_hex: got %h want %h", vec_a, ALL_BLANK); end
    endtask

    task automatic test_basic();
        logic [55:0] e;
        logic exp_busy, exp_done;
        e = '0;
        a1 = 5'd31; a2 = 5'd0; a3 = 5'd9; a4 = 5'd10;
        q_a.push_back(model(31, 0, 9, 10, 1'b0));
        pulse_a();
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_busy = (k <= 29);
            exp_done = (k == 30);
            n_compared++; if (busy_a !== exp_busy) begin n_mismatched++; $display("[TB] FAIL basic_busy edge %0d: got %b want %b", k, busy_a, exp_busy); end
            n_compared++; if (done_a !== exp_done) begin n_mismatched++; $display("[TB] FAIL basic_done edge %0d: got %b want %b", k, done_a, exp_done); end
            if (k == 29) begin
                n_compared++; if (vec_a !== ALL_BLANK) begin n_mismatched++; $display("[TB] FAIL basic_early_hex: got %h want %h", vec_a, ALL_BLANK); end
            end
            if (k == 30) begin
                e = q_a.pop_front();
                n_compared++; if (vec_a !== e) begin n_mismatched++; $display("[TB] FAIL basic_hex: got %h want %h", vec_a, e); end
            end
        end
        tick();
        n_compared++; if (done_a !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_done_width: got %b want 0", done_a); end
        n_compared++; if (vec_a !== e) begin n_mismatched++; $display("[TB] FAIL basic_hold: got %h want %h", vec_a, e); end
    endtask

    task automatic test_ignore_start();
        int dones, done_edge;
        logic [55:0] e;
        a1 = 5'd31; a2 = 5'd12; a3 = 5'd3; a4 = 5'd28;
        q_a.push_back(model(31, 12, 3, 28, 1'b0));
        pulse_a();
        dones = 0;
        done_edge = -1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (done_a === 1'b1) begin
                dones++;
                if (done_edge < 0) begin
                    done_edge = k;
                    e = q_a.pop_front();
                    last_a = e;
                    n_compared++; if (vec_a !== e) begin n_mismatched++; $display("[TB] FAIL ignore_hex: got %h want %h", vec_a, e); end
                end
            end
            if (k == 4) begin a1 = 5'd7; start_a = 1'b1; end
            if (k == 5) start_a = 1'b0;
        end
        n_compared++; if (dones !== 1) begin n_mismatched++; $display("[TB] FAIL ignore_done_count: got %0d want 1", dones); end
        n_compared++; if (done_edge !== 30) begin n_mismatched++; $display("[TB] FAIL ignore_done_edge: got %0d want 30", done_edge); end
        n_compared++; if ({hex_a[7], hex_a[6]} !== {seg(3), seg(1)}) begin n_mismatched++; $display("[TB] FAIL ignore_in1: got %h want %h", {hex_a[7], hex_a[6]}, {seg(3), seg(1)}); end
    endtask

    task automatic test_reset_mid();
        int seen, c;
        logic [55:0] e;
        a1 = 5'd17; a2 = 5'd22; a3 = 5'd8; a4 = 5'd30;
        pulse_a();
        seen = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (done_a !== 1'b0) seen++;
        end
        n_compared++; if (vec_a !== last_a) begin n_mismatched++; $display("[TB] FAIL mid_hold: got %h want %h", vec_a, last_a); end
        reset = 1'b1;
        start_a = 1'b1;
        tick();
        n_compared++; if (vec_a !== ALL_BLANK) begin n_mismatched++; $display("[TB] FAIL mid_reset_hex: got %h want %h", vec_a, ALL_BLANK); end
        n_compared++; if (busy_a !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_reset_busy: got %b want 0", busy_a); end
        reset = 1'b0;
        start_a = 1'b0;
        repeat (40) begin
            tick();
            if (done_a !== 1'b0 || busy_a !== 1'b0) seen++;
        end
        n_compared++; if (seen !== 0) begin n_mismatched++; $display("[TB] FAIL mid_no_done: got %0d active cycles want 0", seen); end
        q_a.push_back(model(17, 22, 8, 30, 1'b0));
        pulse_a();
        wait_done(0, 40, c);
        n_compared++; if (c !== 30) begin n_mismatched++; $display("[TB] FAIL mid_restart_latency: got %0d want 30", c); end
        e = q_a.pop_front();
        n_compared++; if (vec_a !== e) begin n_mismatched++; $display("[TB] FAIL mid_restart_hex: got %h want %h", vec_a, e); end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [55:0] e;
        a1 = 5'd5; a2 = 5'd19; a3 = 5'd30; a4 = 5'd1;
        q_a.push_back(model(5, 19, 30, 1, 1'b0));
        pulse_a();
        wait_done(0, 40, c);
        n_compared++; if (c !== 30) begin n_mismatched++; $display("[TB] FAIL b2b_first_latency: got %0d want 30", c); end
        e = q_a.pop_front();
        n_compared++; if (vec_a !== e) begin n_mismatched++; $display("[TB] FAIL b2b_first_hex: got %h want %h", vec_a, e); end
        a1 = 5'd26; a2 = 5'd11; a3 = 5'd0; a4 = 5'd14;
        q_a.push_back(model(26, 11, 0, 14, 1'b0));
        pulse_a();
        wait_done(0, 40, c);
        n_compared++; if (c !== 30) begin n_mismatched++; $display("[TB] FAIL b2b_second_latency: got %0d want 30", c); end
        e = q_a.pop_front();
        n_compared++; if (vec_a !== e) begin n_mismatched++; $display("[TB] FAIL b2b_second_hex: got %h want %h", vec_a, e); end
    endtask

    task automatic test_refresh();
        int c;
        logic [55:0] e;
        q_r.push_back(model(4, 13, 0, 25, 1'b0));
        wait_done(2, 70, c);
        n_compared++; if (c < 1) begin n_mismatched++; $display("[TB] FAIL refresh_first_pulse: got %0d want 1..70", c); end
        e = q_r.pop_front();
        n_compared++; if (vec_r !== e) begin n_mismatched++; $display("[TB] FAIL refresh_hex_25: got %h want %h", vec_r, e); end
        q_r.push_back(model(4, 13, 0, 25, 1'b0));
        wait_done(2, 70, c);
        n_compared++; if (c !== 64) begin n_mismatched++; $display("[TB] FAIL refresh_period_1: got %0d want 64", c); end
        e = q_r.pop_front();
        n_compared++; if (vec_r !== e) begin n_mismatched++; $display("[TB] FAIL refresh_hex_repeat: got %h want %h", vec_r, e); end
        r4 = 5'd17;
        q_r.push_back(model(4, 13, 0, 17, 1'b0));
        wait_done(2, 70, c);
        n_compared++; if (c !== 64) begin n_mismatched++; $display("[TB] FAIL refresh_period_2: got %0d want 64", c); end
        e = q_r.pop_front();
        n_compared++; if (vec_r !== e) begin n_mismatched++; $display("[TB] FAIL refresh_hex_17: got %h want %h", vec_r, e); end
        n_compared++; if ({hex_r[1], hex_r[0]} !== {seg(1), seg(7)}) begin n_mismatched++; $display("[TB] FAIL refresh_hex10: got %h want %h", {hex_r[1], hex_r[0]}, {seg(1), seg(7)}); end
    endtask

    task automatic test_blank_zero();
        int c;
        logic [55:0] e;
        b1 = 5'd31; b2 = 5'd5; b3 = 5'd20; b4 = 5'd0;
        q_b.push_back(model(31, 5, 20, 0, 1'b1));
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_done(1, 40, c);
        n_compared++; if (c !== 30) begin n_mismatched++; $display("[TB] FAIL blz_latency: got %0d want 30", c); end
        e = q_b.pop_front();
        n_compared++; if (vec_b !== e) begin n_mismatched++; $display("[TB] FAIL blz_hex: got %h want %h", vec_b, e); end
        n_compared++; if (hex_b[5] !== BLANK) begin n_mismatched++; $display("[TB] FAIL blz_hex5: got %b want %b", hex_b[5], BLANK); end
        n_compared++; if (hex_b[2] !== seg(0)) begin n_mismatched++; $display("[TB] FAIL blz_hex2: got %b want %b", hex_b[2], seg(0)); end
        n_compared++; if ({hex_b[1], hex_b[0]} !== {BLANK, seg(0)}) begin n_mismatched++; $display("[TB] FAIL blz_hex10: got %h want %h", {hex_b[1], hex_b[0]}, {BLANK, seg(0)}); end
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_r = 1'b0;
        a1 = '0; a2 = '0; a3 = '0; a4 = '0;
        b1 = '0; b2 = '0; b3 = '0; b4 = '0;
        r1 = 5'd4; r2 = 5'd13; r3 = 5'd0; r4 = 5'd25;
        last_a = ALL_BLANK;
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_refresh();
        test_blank_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/score_hex_display.md
Name: score_hex_display

Overview:
- Display back-end for the game-select output path.
- Consumes the four 5-bit display values (player/dealer hands, score, random number; range 0–31) that the selector drives.
- Snapshots all four values, converts each to two decimal digits with a sequential shift-add-3 (double-dabble) engine, and drives eight active-low 7-segment displays.
- All eight digits update together in one cycle, so digits from old and new values never mix on the displays.

Parameters:
- REFRESH_PERIOD, 0, cycles between automatic conversions; 0 = manual start only; nonzero values must be ≥ 32.
- BLANK_LEADING_ZERO, 0, 1 = blank the tens digit when it is 0.

Ports:
- Clock  input  1  system clock (CLOCK_50 domain).
- reset  input  1  synchronous, active-high reset.
- start  input  1  request one conversion of all four inputs; sampled only in IDLE.
- in1  input  5  value shown on HEX7 (tens) / HEX6 (ones).
- in2  input  5  value shown on HEX5 / HEX4.
- in3  input  5  value shown on HEX3 / HEX2.
- in4  input  5  value shown on HEX1 / HEX0.
- HEX7..HEX0  output  7 each  active-low segments, bit order {g,f,e,d,c,b,a}.
- busy  output  1  high from the cycle after start is accepted until COMMIT completes.
- done  output  1  one-cycle pulse when new HEX values become visible.

Behaviour:
- Reset is synchronous and active-high; Clock is the only clock.
- Reset values:
  - HEX7..HEX0 = 7'b1111111 (blank).
  - busy = 0, done = 0.
  - State = IDLE, channel index = 0, refresh counter = 0.
  - Snapshot and BCD registers cleared.
- Start source:
  - trigger = start OR (REFRESH_PERIOD ≠ 0 and refresh counter == REFRESH_PERIOD−1).
  - The refresh counter wraps to 0 after reaching REFRESH_PERIOD−1.
- FSM states and transitions:
  - IDLE: on trigger → CAPTURE. Otherwise stay.
  - CAPTURE (1 cycle): latch in1..in4 into snapshot registers; channel = 0.
  - LOAD (1 cycle): shift reg = snapshot[channel]; tens = 0; ones = 0; bit counter = 0.
  - SHIFT (5 cycles): each cycle, first add 3 to ones if ones ≥ 5, then shift {tens[1:0], ones[3:0], shift[4:0]} left by 1. Leave after the 5th shift.
  - STORE (1 cycle): write {tens, ones} into the digit buffer for this channel. If channel == 3 → COMMIT; else channel += 1 → LOAD.
  - COMMIT (1 cycle): decode all eight digits into the HEX registers; pulse done; → IDLE.
- Latency:
  - Trigger sampled at edge 0; HEX outputs and done change at edge 30.
  - Breakdown: 1 (CAPTURE) + 4 × 7 (LOAD + 5 SHIFT + STORE) + 1 (COMMIT).
  - busy is high from edge 1 through edge 29 and low at edge 30.
- Segment codes, active low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Tens digit ranges 0–3; ones digit ranges 0–9. Any other code displays blank.
- BLANK_LEADING_ZERO = 1: a tens digit of 0 displays 7'b1111111. Ones digits are never blanked.
- Boundary conditions:
  - start or auto trigger while not in IDLE: ignored, not queued. The refresh counter keeps running.
  - Input changes after CAPTURE do not affect the result in progress.
  - Reset mid-conversion aborts the conversion: HEX outputs return to blank and no done pulse is produced.
  - Trigger in the same cycle as reset: reset wins.
  - Trigger in the cycle after COMMIT (state back in IDLE): accepted.
- HEX outputs hold their values between commits.

Test Plan:
- Reset, then idle 40 cycles with start = 0 and REFRESH_PERIOD = 0 → all HEX = 7'b1111111; busy = 0; done never pulses.
- in1 = 31, in2 = 0, in3 = 9, in4 = 10, start pulsed 1 cycle → at edge 30 done = 1 for exactly 1 cycle; HEX7/6 = 3/1, HEX5/4 = 0/0, HEX3/2 = 0/9, HEX1/0 = 1/0 (codes per table).
- Start accepted, then at edge 5 change in1 to 7 and pulse start again → result still shows 31 on HEX7/6; only one done pulse, at edge 30.
- Assert reset at edge 15 of a conversion → HEX blank at edge 16; no done pulse; a new start after reset converts normally in 30 cycles.
- REFRESH_PERIOD = 64, start tied low, in4 = 25 → done pulses every 64 cycles; HEX1/0 = 2/5; changing in4 to 17 shows 1/7 after the next pulse.
- BLANK_LEADING_ZERO = 1, in2 = 5, in3 = 20 → HEX5 = 7'b1111111, HEX4 = "5"; HEX3 = "2", HEX2 = "0" (ones zero not blanked).
